aes_bus_wrapper: RTL and testbench

- Narrow-bus front end for an iterative AES cipher supporting AES-128 and AES-256, encrypt and decrypt.
- A host drives a 4-bit command address and a 16-bit write word each clock, and reads one 8-bit value per clock.
- The block holds config, key, block and result registers, sequences init (key expansion) and next (one block), and instantiates the cipher core.

---
 rtl/aes_pkg.sv | 138 +++++++++++++
 rtl/aes_core.sv | 146 ++++++++++++++
 rtl/aes_bus_wrapper.sv | 113 +++++++++++
 tb/tb_aes_bus_wrapper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the narrow-bus AES front end and its iterative cipher core.
// Contents: bus address codes, config/start/status bit positions, key-length and core-state
// enums, and the GF(2^8) and round-transform helper functions used by the core.
// State and key byte 0 sit in bits [127:120]; bytes are column-major (byte r + 4*c).
package aes_pkg;

  localparam logic [3:0] AddrIdle   = 4'd0;
  localparam logic [3:0] AddrConfig = 4'd1;
  localparam logic [3:0] AddrKey    = 4'd2;
  localparam logic [3:0] AddrBlock  = 4'd3;
  localparam logic [3:0] AddrStatus = 4'd5;
  localparam logic [3:0] AddrStart  = 4'd6;
  localparam logic [3:0] AddrResult = 4'd7;

  localparam int unsigned CfgEncdecBit   = 0;
  localparam int unsigned CfgKeylenBit   = 1;
  localparam int unsigned StartInitBit   = 0;
  localparam int unsigned StartNextBit   = 1;
  localparam int unsigned StatusReadyBit = 0;
  localparam int unsigned StatusValidBit = 1;
  localparam int unsigned StatusBusyBit  = 2;

  typedef enum logic {AES_128 = 1'b0, AES_256 = 1'b1} aes_keylen_e;

  typedef enum logic [1:0] {StIdle, StKeyExp, StBlock} aes_core_st_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-boxes built from the field inverse and the affine map rather than a ROM table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // Circulant column mix; (2,3,1,1) for MixColumns, (e,b,d,9) for InvMixColumns.
  function automatic logic [127:0] mix_all(input logic [127:0] s, input logic [7:0] c0,
                                           input logic [7:0] c1, input logic [7:0] c2,
                                           input logic [7:0] c3);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, c0) ^ gf_mul(a1, c1) ^ gf_mul(a2, c2) ^ gf_mul(a3, c3);
      o[119 - 32*c -: 8] = gf_mul(a0, c3) ^ gf_mul(a1, c0) ^ gf_mul(a2, c1) ^ gf_mul(a3, c2);
      o[111 - 32*c -: 8] = gf_mul(a0, c2) ^ gf_mul(a1, c3) ^ gf_mul(a2, c0) ^ gf_mul(a3, c1);
      o[103 - 32*c -: 8] = gf_mul(a0, c1) ^ gf_mul(a1, c2) ^ gf_mul(a2, c3) ^ gf_mul(a3, c0);
    end
    return o;
  endfunction

  // Round constant for index i (1 -> 01, 2 -> 02, ... 10 -> 36).
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    rc = 8'h01;
    for (int j = 1; j < 10; j++) begin
      if (j < int'(i)) rc = xtime(rc);
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_core.sv
// Iterative FIPS-197 AES cipher, AES-128/AES-256, encrypt and decrypt, one round per clock.
// init expands key into a round-key table (one round key per clock); next runs one block
// using the table. init/next are accepted only while idle, init taking priority.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   init, next          one-cycle start pulses
//   encdec              1 = encrypt (sampled on next)
//   keylen              1 = 256-bit key (sampled on init)
//   key[255:0]          AES-128 uses key[255:128]
//   block[127:0]        input block
//   key_ready           level, high once expansion completes, low from init until then
//   busy                expansion or block in progress
//   result[127:0]       output block, valid with result_done
//   result_done         one-cycle pulse when a block finishes
module aes_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic         encdec,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [127:0] block,
  output logic         key_ready,
  output logic         busy,
  output logic [127:0] result,
  output logic         result_done
);

  aes_core_st_e r_fsm, w_fsm_d;
  aes_keylen_e  r_klen;
  logic         r_enc, r_key_ready, r_done;
  logic [3:0]   r_kidx, r_round, w_nr, w_rk_idx;
  logic [127:0] r_kp1, r_kp2, r_state;
  logic [127:0] r_rk [15];
  logic [127:0] w_rk_base, w_rk_new, w_rk_round, w_sb, w_round_out;
  logic [31:0]  w_ktmp;
  logic         w_last;

  assign w_nr = (r_klen == AES_256) ? 4'd14 : 4'd10;

  // Next round key: r_kp1 is the previous round key, r_kp2 the one before it.
  always_comb begin
    w_rk_base = (r_klen == AES_256) ? r_kp2 : r_kp1;
    w_ktmp    = r_kp1[31:0];
    if (r_klen == AES_128 || !r_kidx[0]) begin
      w_ktmp         = sub_word({w_ktmp[23:0], w_ktmp[31:24]});
      w_ktmp[31:24]  = w_ktmp[31:24] ^
                       rcon((r_klen == AES_256) ? {1'b0, r_kidx[3:1]} : r_kidx);
    end else begin
      w_ktmp = sub_word(w_ktmp);
    end
    w_rk_new[127:96] = w_rk_base[127:96] ^ w_ktmp;
    w_rk_new[95:64]  = w_rk_base[95:64] ^ w_rk_new[127:96];
    w_rk_new[63:32]  = w_rk_base[63:32] ^ w_rk_new[95:64];
    w_rk_new[31:0]   = w_rk_base[31:0] ^ w_rk_new[63:32];
  end

  always_comb begin
    w_rk_idx   = r_enc ? r_round : (w_nr - r_round);
    w_rk_round = r_rk[w_rk_idx];
    w_last     = (r_round == w_nr);
    if (r_enc) begin
      w_sb        = shift_rows(sub_bytes(r_state));
      w_round_out = (w_last ? w_sb : mix_all(w_sb, 8'h02, 8'h03, 8'h01, 8'h01)) ^ w_rk_round;
    end else begin
      w_sb        = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk_round;
      w_round_out = w_last ? w_sb : mix_all(w_sb, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= StIdle;
    else     r_fsm <= w_fsm_d;
  end

  always_comb begin
    w_fsm_d = r_fsm;
    case (r_fsm)
      StIdle: begin
        if (init)      w_fsm_d = StKeyExp;
        else if (next) w_fsm_d = StBlock;
      end
      StKeyExp: if (r_kidx == w_nr) w_fsm_d = StIdle;
      StBlock:  if (w_last) w_fsm_d = StIdle;
      default:  w_fsm_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (r_fsm != StIdle);
    key_ready   = r_key_ready;
    result      = r_state;
    result_done = r_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_klen      <= AES_128;
      r_enc       <= 1'b0;
      r_key_ready <= 1'b0;
      r_done      <= 1'b0;
      r_kidx      <= 4'd0;
      r_round     <= 4'd0;
      r_kp1       <= '0;
      r_kp2       <= '0;
      r_state     <= '0;
      for (int i = 0; i < 15; i++) r_rk[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        StIdle: begin
          if (init) begin
            r_klen      <= aes_keylen_e'(keylen);
            r_key_ready <= 1'b0;
            r_rk[0]     <= key[255:128];
            r_rk[1]     <= key[127:0];
            r_kp2       <= key[255:128];
            r_kp1       <= keylen ? key[127:0] : key[255:128];
            r_kidx      <= keylen ? 4'd2 : 4'd1;
          end else if (next) begin
            r_enc   <= encdec;
            r_state <= block ^ (encdec ? r_rk[0] : r_rk[w_nr]);
            r_round <= 4'd1;
          end
        end
        StKeyExp: begin
          r_rk[r_kidx] <= w_rk_new;
          r_kp2        <= r_kp1;
          r_kp1        <= w_rk_new;
          r_kidx       <= r_kidx + 4'd1;
          if (r_kidx == w_nr) r_key_ready <= 1'b1;
        end
        StBlock: begin
          r_state <= w_round_out;
          r_round <= r_round + 4'd1;
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aes_bus_wrapper.sv
// Narrow-bus host front end for aes_core. The host presents a 4-bit command address and a
// 16-bit word each clock; the address is registered into state and every capture and read
// decodes that registered state, so commands act one cycle after they are presented.
// Optional build macro: AES_STATUS_BUSY_EN -> status bit 2 reports busy (else reads 0).
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   address[3:0] command/state select
//   data_in[15:0] write word
//   data_out[7:0] read value, combinational from registered state
module aes_bus_wrapper
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [15:0] data_in,
  output logic [7:0]  data_out
);

  logic [3:0]   r_state, r_prev_state, r_bcnt, r_rcnt;
  logic [4:0]   r_kcnt;
  logic         r_encdec, r_keylen, r_init, r_next, r_key_ready, r_valid, r_core_kr;
  logic [255:0] r_key;
  logic [127:0] r_block, r_result;
  logic         w_core_key_ready, w_core_busy, w_core_done;
  logic [127:0] w_core_result;
  logic         w_busy, w_ready, w_go_init, w_go_next, w_key_wr, w_blk_wr;
  logic [7:0]   w_status;

  // A pulse still in flight to the core counts as busy so it cannot be issued twice.
  assign w_busy    = w_core_busy | r_init | r_next;
  assign w_ready   = r_key_ready & ~w_busy & ~r_valid;
  assign w_go_init = (r_state == AddrStart) & data_in[StartInitBit] & ~w_busy;
  assign w_go_next = (r_state == AddrStart) & ~data_in[StartInitBit] & data_in[StartNextBit] &
                     r_key_ready & ~w_busy;
  assign w_key_wr  = (r_state == AddrKey) & ~r_kcnt[4];
  assign w_blk_wr  = (r_state == AddrBlock) & ~r_bcnt[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= AddrIdle;
      r_prev_state <= AddrIdle;
      r_encdec     <= 1'b0;
      r_keylen     <= 1'b0;
      r_kcnt       <= 5'd0;
      r_bcnt       <= 4'd0;
      r_rcnt       <= 4'd0;
      r_key        <= '0;
      r_block      <= '0;
      r_result     <= '0;
      r_init       <= 1'b0;
      r_next       <= 1'b0;
      r_key_ready  <= 1'b0;
      r_valid      <= 1'b0;
      r_core_kr    <= 1'b0;
    end else begin
      r_state      <= address;
      r_prev_state <= r_state;
      if (r_state == AddrConfig && r_prev_state != AddrConfig) begin
        r_encdec <= data_in[CfgEncdecBit];
        r_keylen <= data_in[CfgKeylenBit];
      end
      // Word counters saturate; {~cnt, 4'hf} is the MSB of word cnt, MSB word first.
      r_kcnt <= (r_state == AddrKey) ? r_kcnt + {4'b0, w_key_wr} : 5'd0;
      r_bcnt <= (r_state == AddrBlock) ? r_bcnt + {3'b0, w_blk_wr} : 4'd0;
      r_rcnt <= (r_state == AddrResult) ? r_rcnt + 4'd1 : 4'd0;
      if (w_key_wr) r_key[{~r_kcnt[3:0], 4'hf} -: 16] <= data_in;
      if (w_blk_wr) r_block[{~r_bcnt[2:0], 4'hf} -: 16] <= data_in;
      r_init    <= w_go_init;
      r_next    <= w_go_next;
      r_core_kr <= w_core_key_ready;
      if (w_go_init || w_key_wr)                    r_key_ready <= 1'b0;
      else if (w_core_key_ready && !r_core_kr)      r_key_ready <= 1'b1;
      if (w_go_init || w_go_next) r_valid <= 1'b0;
      else if (w_core_done)       r_valid <= 1'b1;
      if (w_core_done) r_result <= w_core_result;
    end
  end

  always_comb begin
    w_status                 = 8'h00;
    w_status[StatusReadyBit] = w_ready;
    w_status[StatusValidBit] = r_valid;
`ifdef AES_STATUS_BUSY_EN
    w_status[StatusBusyBit]  = w_busy;
`else
    w_status[StatusBusyBit]  = 1'b0;
`endif
    case (r_state)
      AddrStatus: data_out = w_status;
      AddrStart:  data_out = {4'b0, r_keylen, r_encdec, r_next, r_init};
      AddrResult: data_out = r_result[{~r_rcnt, 3'b111} -: 8];
      default:    data_out = 8'h00;
    endcase
  end

  aes_core u_core (
    .clk         (clk),
    .rst         (rst),
    .init        (r_init),
    .next        (r_next),
    .encdec      (r_encdec),
    .keylen      (r_keylen),
    .key         (r_key),
    .block       (r_block),
    .key_ready   (w_core_key_ready),
    .busy        (w_core_busy),
    .result      (w_core_result),
    .result_done (w_core_done)
  );

endmodule

// File: tb/tb_aes_bus_wrapper.sv
// Self-checking bench for aes_bus_wrapper: a table of FIPS-197 vectors driven over the
// narrow bus with expected result bytes queued at issue and compared as RESULT is read,
// plus hand-written sequences for reset, config, and start-pulse corner cases.
module tb_aes_bus_wrapper;

  localparam logic [3:0] A_IDLE   = 4'd0;
  localparam logic [3:0] A_CONFIG = 4'd1;
  localparam logic [3:0] A_KEY    = 4'd2;
  localparam logic [3:0] A_BLOCK  = 4'd3;
  localparam logic [3:0] A_STATUS = 4'd5;
  localparam logic [3:0] A_START  = 4'd6;
  localparam logic [3:0] A_RESULT = 4'd7;

  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [15:0]  cfg;
    logic [255:0] key;
    int           nwords;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  address = 4'd0;
  logic [15:0] data_in = 16'h0;
  logic [7:0]  data_out;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  vec_t vt [3];

  aes_bus_wrapper dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command cycle, then n data words (MSB word of v first); address drops to IDLE on the last.
  task automatic wr(input logic [3:0] cmd, input logic [255:0] v, input int n);
    address = cmd;
    data_in = 16'h0;
    tick();
    for (int i = 0; i < n; i++) begin
      data_in = v[255 - 16*i -: 16];
      address = (i == n - 1) ? A_IDLE : cmd;
      tick();
    end
    data_in = 16'h0;
  endtask

  task automatic hold(input string name, input logic [3:0] addr, input logic [7:0] want,
                      input int n);
    address = addr;
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, data_out, want);
    end
  endtask

  task automatic poll(input string name, input logic [7:0] want);
    logic [7:0] got;
    got     = 8'hxx;
    address = A_STATUS;
    data_in = 16'h0;
    for (int i = 0; i < 40; i++) begin
      tick();
      got = data_out;
      if (got === want) break;
    end
    check(name, got, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h0003, KEY256, 16, PT, CT256};
    vt[1] = '{16'h0001, KEY128, 8, PT, CT128};
    vt[2] = '{16'h0002, KEY256, 16, CT256, PT};

    repeat (3) tick();
    rst = 1'b0;
    check("reset_out", data_out, 8'h00);

    data_in = 16'habcd;
    hold("idle_abcd", A_IDLE, 8'h00, 5);
    data_in = 16'h0;
    hold("start_after_reset", A_START, 8'h00, 1);

    // Only the first CONFIG cycle writes; data stays 3 throughout.
    address = A_CONFIG;
    data_in = 16'h0003;
    repeat (10) tick();
    data_in = 16'h0;
    hold("start_cfg_0c", A_START, 8'h0c, 1);

    // next without an expanded key must be dropped.
    wr(A_KEY, KEY256, 16);
    wr(A_START, {16'h0002, 240'h0}, 1);
    hold("next_no_key", A_STATUS, 8'h00, 20);

    for (int v = 0; v < 3; v++) begin
      wr(A_CONFIG, {vt[v].cfg, 240'h0}, 1);
      wr(A_KEY, vt[v].key, vt[v].nwords);
      wr(A_START, {16'h0001, 240'h0}, 1);
      poll($sformatf("v%0d_key_ready", v), 8'h01);
      wr(A_BLOCK, {vt[v].blk, 128'h0}, 8);
      wr(A_START, {16'h0002, 240'h0}, 1);
      for (int b = 0; b < 16; b++) exp_q.push_back(vt[v].exp[127 - 8*b -: 8]);
      poll($sformatf("v%0d_valid", v), 8'h02);
      address = A_RESULT;
      for (int b = 0; b < 16; b++) begin
        tick();
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_queue_empty", v), 8'h01, 8'h00);
        end else begin
          check($sformatf("v%0d_byte%0d", v, b), data_out, exp_q.pop_front());
        end
      end
      if (v == 2) begin
        tick();
        check("result_wrap", data_out, PT[127:120]);
      end
    end

    // init and next together: only expansion runs, so no result ever becomes valid.
    wr(A_START, {16'h0003, 240'h0}, 1);
    poll("init_next_same", 8'h01);
    hold("init_next_no_block", A_STATUS, 8'h01, 18);

    // next while expansion is still running is dropped.
    wr(A_START, {16'h0001, 240'h0}, 1);
    wr(A_START, {16'h0002, 240'h0}, 1);
    poll("next_busy_kexp", 8'h01);
    hold("next_busy_dropped", A_STATUS, 8'h01, 18);

    // Reset in the middle of a block aborts it.
    wr(A_BLOCK, {PT, 128'h0}, 8);
    wr(A_START, {16'h0002, 240'h0}, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold("status_after_rst", A_STATUS, 8'h00, 20);
    hold("start_after_rst", A_START, 8'h00, 1);
    hold("result_after_rst", A_RESULT, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
